// File: rtl/clk_div_nch.sv
// clk_div_nch: NCH independent programmable clock dividers with shadowed,
// glitch-free configuration update and per-channel phase reload.
// Optional feature macro: CLK_DIV_NCH_TICK_EN adds a per-channel wrap tick output.
module clk_div_nch #(
    parameter int unsigned NCH     = 4,
    parameter int unsigned CW      = 32,
    parameter int unsigned DEF_MAX = 1000,
    parameter int unsigned DEF_THR = 500,
    parameter int unsigned DEF_PH  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCH-1:0]    en,
    input  logic [NCH-1:0]    phase_rst,
    input  logic              cfg_wr,
    input  logic [3:0]        cfg_ch,
    input  logic [CW-1:0]     cfg_max,
    input  logic [CW-1:0]     cfg_thr,
    input  logic [CW-1:0]     cfg_phase,
    output logic              cfg_err,
    output logic [NCH-1:0]    pend,
    output logic [NCH-1:0]    clk_div,
    output logic [NCH*CW-1:0] cnt
`ifdef CLK_DIV_NCH_TICK_EN
    ,
    output logic [NCH-1:0]    tick
`endif
);

    localparam int unsigned CHW = 4;

    localparam logic [CW-1:0] ONE     = CW'(1);
    localparam logic [CW-1:0] RST_MAX = CW'(DEF_MAX);
    localparam logic [CW-1:0] RST_THR = CW'(DEF_THR);
    localparam logic [CW-1:0] RST_PH  = CW'(DEF_PH);

    logic ch_ok_c;
    logic vals_ok_c;
    logic cfg_ok_c;
    logic cfg_err_q;
    logic cfg_err_d;

    // Write qualification: valid channel and a self-consistent period/high/phase set
    always_comb begin
        ch_ok_c   = ({1'b0, cfg_ch} < (CHW + 1)'(NCH));
        vals_ok_c = (cfg_max >= CW'(2)) && (cfg_thr != '0) &&
                    (cfg_thr < cfg_max) && (cfg_phase < cfg_max);
        cfg_ok_c  = cfg_wr && ch_ok_c && vals_ok_c;
        cfg_err_d = cfg_wr && !(ch_ok_c && vals_ok_c);
    end

    // Rejected-write flag, one cycle after the offending strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_err_q <= 1'b0;
        end else begin
            cfg_err_q <= cfg_err_d;
        end
    end

    assign cfg_err = cfg_err_q;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        logic [CW-1:0] max_a_q, max_a_d, thr_a_q, thr_a_d, ph_a_q, ph_a_d;
        logic [CW-1:0] max_s_q, max_s_d, thr_s_q, thr_s_d, ph_s_q, ph_s_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic          pend_q, pend_d;
        logic          div_q, div_d;
        logic          wr_hit_c;
`ifdef CLK_DIV_NCH_TICK_EN
        logic          tick_q, tick_d;
`endif

        assign wr_hit_c = cfg_ok_c && (cfg_ch == CHW'(gi));

        // Channel next state: phase reload beats counting; the shadow is applied
        // from pre-write values so a same-cycle write stays pending.
        always_comb begin
            max_a_d = max_a_q;
            thr_a_d = thr_a_q;
            ph_a_d  = ph_a_q;
            max_s_d = max_s_q;
            thr_s_d = thr_s_q;
            ph_s_d  = ph_s_q;
            cnt_d   = cnt_q;
            pend_d  = pend_q;
            div_d   = div_q;
`ifdef CLK_DIV_NCH_TICK_EN
            tick_d  = 1'b0;
`endif
            if (phase_rst[gi]) begin
                if (pend_q) begin
                    max_a_d = max_s_q;
                    thr_a_d = thr_s_q;
                    ph_a_d  = ph_s_q;
                    pend_d  = 1'b0;
                end
                cnt_d = ph_a_d;
                div_d = (ph_a_d < thr_a_d);
            end else if (en[gi]) begin
                if (cnt_q >= max_a_q - ONE) begin
                    if (pend_q) begin
                        max_a_d = max_s_q;
                        thr_a_d = thr_s_q;
                        ph_a_d  = ph_s_q;
                        pend_d  = 1'b0;
                    end
                    cnt_d = '0;
                    div_d = 1'b1;
`ifdef CLK_DIV_NCH_TICK_EN
                    tick_d = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + ONE;
                    if (cnt_q == thr_a_q - ONE) begin
                        div_d = 1'b0;
                    end
                end
            end
            if (wr_hit_c) begin
                max_s_d = cfg_max;
                thr_s_d = cfg_thr;
                ph_s_d  = cfg_phase;
                pend_d  = 1'b1;
            end
        end

        // Channel state registers; reset discards any pending shadow
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                max_a_q <= RST_MAX;
                thr_a_q <= RST_THR;
                ph_a_q  <= RST_PH;
                max_s_q <= RST_MAX;
                thr_s_q <= RST_THR;
                ph_s_q  <= RST_PH;
                cnt_q   <= '0;
                pend_q  <= 1'b0;
                div_q   <= 1'b1;
`ifdef CLK_DIV_NCH_TICK_EN
                tick_q  <= 1'b0;
`endif
            end else begin
                max_a_q <= max_a_d;
                thr_a_q <= thr_a_d;
                ph_a_q  <= ph_a_d;
                max_s_q <= max_s_d;
                thr_s_q <= thr_s_d;
                ph_s_q  <= ph_s_d;
                cnt_q   <= cnt_d;
                pend_q  <= pend_d;
                div_q   <= div_d;
`ifdef CLK_DIV_NCH_TICK_EN
                tick_q  <= tick_d;
`endif
            end
        end

        assign cnt[gi*CW +: CW] = cnt_q;
        assign pend[gi]         = pend_q;
        assign clk_div[gi]      = div_q;
`ifdef CLK_DIV_NCH_TICK_EN
        assign tick[gi]         = tick_q;
`endif
    end

endmodule

// File: tb/tb_clk_div_nch.sv
// Directed self-checking bench for clk_div_nch (NCH=4, CW=32, defaults 1000/500/0).
module tb_clk_div_nch;

    localparam int unsigned NCH = 4;
    localparam int unsigned CW  = 32;

    logic              clk;
    logic              rst_n;
    logic [NCH-1:0]    en;
    logic [NCH-1:0]    phase_rst;
    logic              cfg_wr;
    logic [3:0]        cfg_ch;
    logic [CW-1:0]     cfg_max;
    logic [CW-1:0]     cfg_thr;
    logic [CW-1:0]     cfg_phase;
    logic              cfg_err;
    logic [NCH-1:0]    pend;
    logic [NCH-1:0]    clk_div;
    logic [NCH*CW-1:0] cnt;
`ifdef CLK_DIV_NCH_TICK_EN
    logic [NCH-1:0]    tick;
`endif

    int checks   = 0;
    int failures = 0;

    clk_div_nch #(
        .NCH(NCH), .CW(CW), .DEF_MAX(1000), .DEF_THR(500), .DEF_PH(0)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .phase_rst (phase_rst),
        .cfg_wr    (cfg_wr),
        .cfg_ch    (cfg_ch),
        .cfg_max   (cfg_max),
        .cfg_thr   (cfg_thr),
        .cfg_phase (cfg_phase),
        .cfg_err   (cfg_err),
        .pend      (pend),
        .clk_div   (clk_div),
        .cnt       (cnt)
`ifdef CLK_DIV_NCH_TICK_EN
        ,
        .tick      (tick)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n cycles; returns 1 time unit after the rising edge
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [CW-1:0] ch_cnt(input int ch);
        return cnt[ch*CW +: CW];
    endfunction

    task automatic cfg_write(input logic [3:0] ch, input logic [CW-1:0] m,
                             input logic [CW-1:0] t, input logic [CW-1:0] p);
        cfg_wr    = 1'b1;
        cfg_ch    = ch;
        cfg_max   = m;
        cfg_thr   = t;
        cfg_phase = p;
        cyc(1);
        cfg_wr    = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = '0; phase_rst = '0; cfg_wr = 1'b0;
        cfg_ch = '0; cfg_max = '0; cfg_thr = '0; cfg_phase = '0;
        cyc(2);
        checks++; if (cnt !== '0) begin failures++; $display("FAIL reset_cnt got=%h exp=0", cnt); end
        checks++; if (clk_div !== 4'hF) begin failures++; $display("FAIL reset_div got=%b exp=1111", clk_div); end
        checks++; if (pend !== 4'h0) begin failures++; $display("FAIL reset_pend got=%b exp=0000", pend); end
        checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", cfg_err); end
    endtask

    task automatic test_default_period();
        int bad = 0;
        int hi  = 0;
        logic [CW-1:0] exp_c;
        logic exp_d;
        rst_n = 1'b1;
        en    = 4'hF;
        for (int k = 0; k < 2000; k++) begin
            exp_c = CW'(k % 1000);
            exp_d = (k % 1000) < 500;
            for (int ch = 0; ch < NCH; ch++) begin
                if (ch_cnt(ch) !== exp_c || clk_div[ch] !== exp_d) bad++;
            end
            if (k < 1000 && clk_div[0] === 1'b1) hi++;
            cyc(1);
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL default_seq mismatches=%0d exp=0", bad); end
        checks++; if (hi != 500) begin failures++; $display("FAIL default_high got=%0d exp=500", hi); end
        checks++; if (ch_cnt(0) !== 32'd0 || clk_div[0] !== 1'b1) begin
            failures++; $display("FAIL default_wrap cnt=%0d div=%b exp cnt=0 div=1", ch_cnt(0), clk_div[0]);
        end
    endtask

    task automatic test_shadow_switch();
        int bad = 0;
        logic [CW-1:0] exp_c;
        cyc(100);
        cfg_write(4'd1, 32'd10, 32'd3, 32'd0);
        checks++; if (pend !== 4'b0010) begin failures++; $display("FAIL shadow_pend got=%b exp=0010", pend); end
        checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL shadow_err got=%b exp=0", cfg_err); end
        checks++; if (ch_cnt(1) !== 32'd101) begin failures++; $display("FAIL shadow_cnt got=%0d exp=101", ch_cnt(1)); end
        cyc(898);
        checks++; if (ch_cnt(1) !== 32'd999 || pend[1] !== 1'b1 || clk_div[1] !== 1'b0) begin
            failures++; $display("FAIL pre_wrap cnt=%0d pend=%b div=%b exp 999/1/0", ch_cnt(1), pend[1], clk_div[1]);
        end
        cyc(1);
        checks++; if (ch_cnt(1) !== 32'd0 || pend[1] !== 1'b0 || clk_div[1] !== 1'b1) begin
            failures++; $display("FAIL apply_wrap cnt=%0d pend=%b div=%b exp 0/0/1", ch_cnt(1), pend[1], clk_div[1]);
        end
        for (int j = 0; j < 30; j++) begin
            exp_c = CW'(j % 10);
            if (ch_cnt(1) !== exp_c || clk_div[1] !== ((j % 10) < 3)) bad++;
            cyc(1);
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL new_period mismatches=%0d exp=0", bad); end
    endtask

    task automatic test_illegal();
        logic [3:0]    chv  [5];
        logic [CW-1:0] maxv [5];
        logic [CW-1:0] thrv [5];
        logic [CW-1:0] phv  [5];
        chv  = '{4'd1, 4'd1, 4'd1, 4'd1, 4'd15};
        maxv = '{32'd1, 32'd10, 32'd10, 32'd10, 32'd10};
        thrv = '{32'd1, 32'd0, 32'd10, 32'd3, 32'd3};
        phv  = '{32'd0, 32'd0, 32'd0, 32'd10, 32'd0};
        for (int v = 0; v < 5; v++) begin
            cfg_write(chv[v], maxv[v], thrv[v], phv[v]);
            checks++; if (cfg_err !== 1'b1 || pend !== 4'h0) begin
                failures++; $display("FAIL illegal_%0d err=%b pend=%b exp err=1 pend=0000", v, cfg_err, pend);
            end
            cyc(1);
            checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL illegal_pulse_%0d err=%b exp=0", v, cfg_err); end
        end
        checks++; if (ch_cnt(1) !== 32'd0 || clk_div[1] !== 1'b1) begin
            failures++; $display("FAIL illegal_keep cnt=%0d div=%b exp 0/1", ch_cnt(1), clk_div[1]);
        end
        cyc(3);
        checks++; if (ch_cnt(1) !== 32'd3 || clk_div[1] !== 1'b0) begin
            failures++; $display("FAIL illegal_keep2 cnt=%0d div=%b exp 3/0", ch_cnt(1), clk_div[1]);
        end
    endtask

    task automatic test_phase_align();
        int bad = 0;
        logic [CW-1:0] exp_c;
        cfg_write(4'd0, 32'd8, 32'd4, 32'd2);
        cfg_write(4'd2, 32'd8, 32'd4, 32'd2);
        checks++; if (pend[0] !== 1'b1 || pend[2] !== 1'b1) begin failures++; $display("FAIL align_pend got=%b exp x1x1", pend); end
        phase_rst = 4'b0101;
        cyc(1);
        phase_rst = 4'b0000;
        checks++; if (ch_cnt(0) !== 32'd2 || ch_cnt(2) !== 32'd2) begin
            failures++; $display("FAIL align_cnt c0=%0d c2=%0d exp 2/2", ch_cnt(0), ch_cnt(2));
        end
        checks++; if (clk_div[0] !== 1'b1 || clk_div[2] !== 1'b1 || pend !== 4'h0) begin
            failures++; $display("FAIL align_div div=%b pend=%b exp div x1x1 pend 0000", clk_div, pend);
        end
        for (int j = 0; j < 24; j++) begin
            exp_c = CW'((2 + j) % 8);
            if (ch_cnt(0) !== exp_c || ch_cnt(2) !== exp_c) bad++;
            if (clk_div[0] !== (((2 + j) % 8) < 4) || clk_div[2] !== clk_div[0]) bad++;
            cyc(1);
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL align_track mismatches=%0d exp=0", bad); end
    endtask

    task automatic test_write_with_phase_rst();
        cfg_wr = 1'b1; cfg_ch = 4'd0; cfg_max = 32'd6; cfg_thr = 32'd2; cfg_phase = 32'd1;
        phase_rst = 4'b0001;
        cyc(1);
        cfg_wr = 1'b0; phase_rst = 4'b0000;
        checks++; if (ch_cnt(0) !== 32'd2 || clk_div[0] !== 1'b1 || pend[0] !== 1'b1) begin
            failures++; $display("FAIL wr_prst cnt=%0d div=%b pend=%b exp 2/1/1", ch_cnt(0), clk_div[0], pend[0]);
        end
        cyc(6);
        checks++; if (ch_cnt(0) !== 32'd0 || clk_div[0] !== 1'b1 || pend[0] !== 1'b0) begin
            failures++; $display("FAIL wr_prst_apply cnt=%0d div=%b pend=%b exp 0/1/0", ch_cnt(0), clk_div[0], pend[0]);
        end
        cyc(2);
        checks++; if (ch_cnt(0) !== 32'd2 || clk_div[0] !== 1'b0) begin
            failures++; $display("FAIL wr_prst_thr cnt=%0d div=%b exp 2/0", ch_cnt(0), clk_div[0]);
        end
    endtask

    task automatic test_enable_freeze();
        int bad = 0;
        phase_rst = 4'b1000;
        cyc(1);
        phase_rst = 4'b0000;
        checks++; if (ch_cnt(3) !== 32'd0 || clk_div[3] !== 1'b1) begin
            failures++; $display("FAIL frz_start cnt=%0d div=%b exp 0/1", ch_cnt(3), clk_div[3]);
        end
        cyc(5);
        checks++; if (ch_cnt(3) !== 32'd5) begin failures++; $display("FAIL frz_at5 got=%0d exp=5", ch_cnt(3)); end
        en = 4'b0111;
        cfg_write(4'd3, 32'd4, 32'd2, 32'd0);
        for (int j = 0; j < 19; j++) begin
            if (ch_cnt(3) !== 32'd5 || clk_div[3] !== 1'b1 || pend[3] !== 1'b1) bad++;
            cyc(1);
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL frz_hold mismatches=%0d exp=0", bad); end
        en = 4'hF;
        cyc(1);
        checks++; if (ch_cnt(3) !== 32'd6 || pend[3] !== 1'b1) begin
            failures++; $display("FAIL frz_resume cnt=%0d pend=%b exp 6/1", ch_cnt(3), pend[3]);
        end
        cyc(1);
        rst_n = 1'b0;
        #1;
        checks++; if (cnt !== '0 || clk_div !== 4'hF || pend !== 4'h0 || cfg_err !== 1'b0) begin
            failures++; $display("FAIL mid_reset cnt=%h div=%b pend=%b err=%b exp 0/1111/0000/0", cnt, clk_div, pend, cfg_err);
        end
        cyc(1);
        rst_n = 1'b1;
        cyc(4);
        checks++; if (ch_cnt(3) !== 32'd4 || clk_div[3] !== 1'b1 || pend !== 4'h0) begin
            failures++; $display("FAIL post_reset cnt=%0d div=%b pend=%b exp 4/1/0000", ch_cnt(3), clk_div[3], pend);
        end
    endtask

`ifdef CLK_DIV_NCH_TICK_EN
    task automatic test_tick();
        int bad = 0;
        cfg_write(4'd0, 32'd4, 32'd2, 32'd0);
        phase_rst = 4'b0001;
        cyc(1);
        phase_rst = 4'b0000;
        checks++; if (ch_cnt(0) !== 32'd0 || tick[0] !== 1'b0) begin
            failures++; $display("FAIL tick_prst cnt=%0d tick=%b exp 0/0", ch_cnt(0), tick[0]);
        end
        for (int j = 1; j <= 12; j++) begin
            cyc(1);
            if (tick[0] !== ((j % 4) == 0) || ch_cnt(0) !== CW'(j % 4)) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL tick_seq mismatches=%0d exp=0", bad); end
    endtask
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_default_period();
        test_shadow_switch();
        test_illegal();
        test_phase_align();
        test_write_with_phase_rst();
        test_enable_freeze();
`ifdef CLK_DIV_NCH_TICK_EN
        test_tick();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clk_div_nch.md
CLK_DIV_NCH -- requirements
Module: clk_div_nch

Interface
REQ-001 SHALL have parameter NCH, 4, number of independent divider channels (1..16).
REQ-002 SHALL have parameter CW, 32, counter/config width per channel.
REQ-003 SHALL have parameters DEF_MAX, 1000; DEF_THR, 500; DEF_PH, 0. These are the per-channel reset values of period, high-time and phase.
REQ-004 SHALL have port clk  in  1  the single clock; all logic is clocked on its rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous and active-low.
REQ-006 SHALL have port en  in  NCH  per-channel count enable.
REQ-007 SHALL have port phase_rst  in  NCH  per-channel synchronous phase reload request.
REQ-008 SHALL have port cfg_wr  in  1  single-cycle config write strobe.
REQ-009 SHALL have port cfg_ch  in  4  target channel of the config write.
REQ-010 SHALL have ports cfg_max, cfg_thr, cfg_phase  in  CW each  carrying the period, high-time and phase to write.
REQ-011 SHALL have port cfg_err  out  1  one-cycle pulse flagging a rejected write.
REQ-012 SHALL have port pend  out  NCH  a shadow config is waiting to be applied.
REQ-013 SHALL have port clk_div  out  NCH  divided clock outputs.
REQ-014 SHALL have port cnt  out  NCH*CW  per-channel counters; channel i occupies bits [i*CW +: CW].

Function
REQ-015 Each channel SHALL hold active registers (max_a, thr_a, ph_a) and shadow registers (max_s, thr_s, ph_s) plus a pend bit.
REQ-016 A cfg_wr with cfg_ch<NCH and legal values SHALL load that channel's shadow and set its pend on the next edge.
REQ-017 A write SHALL be legal only if cfg_max>=2, 1<=cfg_thr<cfg_max and cfg_phase<cfg_max.
REQ-018 An illegal write, or one with cfg_ch>=NCH, SHALL change no state and SHALL pulse cfg_err high for exactly one cycle.
REQ-019 A second write before apply SHALL overwrite the shadow; last write wins.
REQ-020 When en[i]=1 and phase_rst[i]=0, the counter SHALL step as follows: cnt = (cnt < max_a-1) ? cnt+1 : 0.
REQ-021 clk_div[i] SHALL go 1 on the edge where cnt==max_a-1 and 0 on the edge where cnt==thr_a-1. The output is therefore high for thr_a cycles and low for max_a-thr_a cycles per period.
REQ-022 On a wrap edge (cnt==max_a-1, en=1) with pend=1, the channel SHALL copy shadow to active, clear pend, and set cnt=0 and clk_div=1. The new period therefore starts glitch-free, with no partial period.
REQ-023 When en[i]=0, cnt, clk_div and pend SHALL hold; no shadow apply occurs.
REQ-024 phase_rst[i]=1 SHALL take priority over en and counting.
REQ-025 On phase_rst[i], if pend=1 the channel SHALL first apply the shadow as in REQ-022. It SHALL then set cnt=ph and clk_div=(ph<thr), using the applied values.
REQ-026 If cfg_wr and phase_rst hit the same channel in the same cycle, phase_rst SHALL use the pre-write registers, and the new write SHALL remain pending.
REQ-027 Channels SHALL be fully independent. Asserting phase_rst on multiple channels in the same cycle SHALL phase-align them.
REQ-028 Counter arithmetic SHALL be unsigned CW-bit with no overflow; max_a<=2^CW-1 is guaranteed by the config width.

Reset
REQ-029 While rst_n=0, every channel SHALL have cnt=0 and clk_div=1.
REQ-030 While rst_n=0, active and shadow registers SHALL equal DEF_MAX/DEF_THR/DEF_PH, pend=0 and cfg_err=0.
REQ-031 Reset asserted mid-period or with pend=1 SHALL discard the pending config.
REQ-032 After reset deasserts, counting SHALL resume from cnt=0 on the first edge with en=1.

Configuration
REQ-033 With macro CLK_DIV_NCH_TICK_EN defined, the block SHALL add output tick (NCH). tick[i] SHALL be a one-cycle registered pulse high in each cycle where cnt[i]==0 as the result of a wrap, and never as the result of reset or phase_rst.
REQ-034 Without CLK_DIV_NCH_TICK_EN, the tick port and its logic SHALL be absent; all other behaviour is unchanged.

Verification
REQ-035 Reset, en=all 1, defaults: ch0 clk_div high exactly 500 cycles, then low exactly 500 cycles, repeating; cnt sequence 0..999,0.
REQ-036 Write ch1 max=10,thr=3 mid-period: pend[1]=1 until the wrap; following periods show 3 high/7 low; no runt pulse at the switch.
REQ-037 Writes max=1; thr=0; thr=max; phase=max; cfg_ch=15 with NCH=4: each pulses cfg_err once; pend and active values unchanged.
REQ-038 ch0,ch2 set max=8,thr=4,ph=2, phase_rst=0101 in the same cycle: both channels show cnt=2, clk_div=1 on the next edge and stay identical thereafter.
REQ-039 en[3]=0 for 20 cycles at cnt=5: cnt[3] and clk_div[3] frozen; resume at cnt=6 when en returns to 1. Separately, rst_n pulsed low at cnt=7 with pend=1: cnt=0, clk_div=1, pend=0.
REQ-040 With CLK_DIV_NCH_TICK_EN and max=4: tick[0] pulses every 4 cycles coincident with cnt=0; no pulse after phase_rst with ph=0.
